// File: rtl/bist_engine_if.sv
// rtl/bist_engine_if.sv - table-load and core-side BIST bus bundle for bist_engine
interface bist_engine_if #(
    parameter int STIM_W = 5,
    parameter int RESP_W = 4
);
    logic              load_en;
    logic [STIM_W-1:0] load_stim;
    logic [RESP_W-1:0] load_exp;
    logic [RESP_W-1:0] load_mask;
    logic              load_stop;
    logic [STIM_W-1:0] bist_out;
    logic [RESP_W-1:0] bist_in;

    // master: TAP/core side that loads the table and returns responses
    modport master (
        output load_en, load_stim, load_exp, load_mask, load_stop, bist_in,
        input  bist_out
    );

    modport slave (
        input  load_en, load_stim, load_exp, load_mask, load_stop, bist_in,
        output bist_out
    );
endinterface

// File: rtl/bist_engine.sv
// rtl/bist_engine.sv - vector-table BIST sequencer with masked, latency-compensated compare
// Optional: define STOP_ON_FAIL_EN to stop issuing vectors after the first mismatch.
module bist_engine #(
    parameter int DEPTH  = 256,
    parameter int STIM_W = 5,
    parameter int RESP_W = 4,
    parameter int LAT    = 1,
    parameter int CNT_W  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tlr,
    input  logic             run,
    bist_engine_if.slave     bus,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [CNT_W-1:0] err_cnt,
    output logic [AW-1:0]    fail_addr,
    output logic [AW:0]      load_cnt,
    output logic [15:0]      result
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [STIM_W-1:0] stim_mem [DEPTH];
    logic [RESP_W-1:0] exp_mem  [DEPTH];
    logic [RESP_W-1:0] mask_mem [DEPTH];
    logic              stop_mem [DEPTH];

    logic [1:0]    state;
    logic [AW-1:0] pc;
    logic          res_valid;
    logic [LAT-1:0] pipe_valid;
    logic [AW-1:0] pipe_addr [LAT];

    logic          load_accept;
    logic          last_vec;
    logic          issue;
    logic          stop_hit;
    logic          mismatch;
    logic [AW-1:0] cmp_addr;
    logic [LAT-1:0] valid_shift;
    logic [15:0]   addr_img;

    assign load_accept = (state == S_IDLE) && !tlr && bus.load_en
                         && (load_cnt < (AW+1)'(DEPTH));
    assign last_vec    = ((AW+1)'(pc) == load_cnt - (AW+1)'(1)) || stop_mem[pc];

    // The last pipe stage lines up with the response to the token issued LAT cycles ago.
    assign cmp_addr = pipe_addr[LAT-1];
    assign mismatch = pipe_valid[LAT-1]
                      && (|((bus.bist_in ^ exp_mem[cmp_addr]) & mask_mem[cmp_addr]));

`ifdef STOP_ON_FAIL_EN
    assign stop_hit = (state == S_RUN) && mismatch;
`else
    assign stop_hit = 1'b0;
`endif

    assign issue        = (state == S_RUN) && !stop_hit;
    assign bus.bist_out = issue ? stim_mem[pc] : '0;
    // Valid bits as they will be after this cycle's shift, ignoring any new issue.
    assign valid_shift  = LAT'(pipe_valid << 1);

    assign busy = (state == S_RUN) || (state == S_DRAIN);
    assign done = (state == S_DONE);

    if (AW >= 16) begin : g_addr_trunc
        assign addr_img = fail_addr[15:0];
    end else begin : g_addr_ext
        assign addr_img = {{(16-AW){1'b0}}, fail_addr};
    end

    assign result = fail ? addr_img : (res_valid ? 16'hFFFF : 16'h0000);

    // Table storage is deliberately left out of reset so a TLR does not force a reload.
    always_ff @(posedge clk) begin
        if (load_accept) begin
            stim_mem[load_cnt[AW-1:0]] <= bus.load_stim;
            exp_mem[load_cnt[AW-1:0]]  <= bus.load_exp;
            mask_mem[load_cnt[AW-1:0]] <= bus.load_mask;
            stop_mem[load_cnt[AW-1:0]] <= bus.load_stop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= '0;
            load_cnt   <= '0;
            fail       <= 1'b0;
            err_cnt    <= '0;
            fail_addr  <= '0;
            res_valid  <= 1'b0;
            pipe_valid <= '0;
            for (int i = 0; i < LAT; i++) pipe_addr[i] <= '0;
        end else if (tlr) begin
            state      <= S_IDLE;
            pc         <= '0;
            load_cnt   <= '0;
            fail       <= 1'b0;
            err_cnt    <= '0;
            fail_addr  <= '0;
            res_valid  <= 1'b0;
            pipe_valid <= '0;
            for (int i = 0; i < LAT; i++) pipe_addr[i] <= '0;
        end else begin
            if (mismatch) begin
                if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
                if (!fail) begin
                    fail      <= 1'b1;
                    fail_addr <= cmp_addr;
                end
            end

            pipe_valid   <= valid_shift | LAT'(issue);
            pipe_addr[0] <= pc;
            for (int i = 1; i < LAT; i++) pipe_addr[i] <= pipe_addr[i-1];

            case (state)
                S_IDLE: begin
                    if (load_accept) load_cnt <= load_cnt + (AW+1)'(1);
                    if (run) begin
                        pc        <= '0;
                        fail      <= 1'b0;
                        err_cnt   <= '0;
                        fail_addr <= '0;
                        if (load_cnt == '0) begin
                            state     <= S_DONE;
                            res_valid <= 1'b1;
                        end else begin
                            state     <= S_RUN;
                            res_valid <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (!run) begin
                        state      <= S_IDLE;
                        pc         <= '0;
                        pipe_valid <= '0;
                    end else if (stop_hit || last_vec) begin
                        state <= S_DRAIN;
                    end else begin
                        pc <= pc + AW'(1);
                    end
                end
                S_DRAIN: begin
                    if (!run) begin
                        state      <= S_IDLE;
                        pc         <= '0;
                        pipe_valid <= '0;
                    end else if (valid_shift == '0) begin
                        state     <= S_DONE;
                        res_valid <= 1'b1;
                    end
                end
                default: begin
                    if (!run) begin
                        state <= S_IDLE;
                        pc    <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bist_engine.sv
// tb/tb_bist_engine.sv - table-driven, scoreboarded bench for bist_engine
module tb_bist_engine;
    localparam int DEPTH  = 8;
    localparam int STIM_W = 5;
    localparam int RESP_W = 4;
    localparam int LAT    = 1;
    localparam int CNT_W  = 2;
    localparam int AW     = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tlr = 1'b0;
    logic run = 1'b0;
    logic busy, done, fail;
    logic [CNT_W-1:0] err_cnt;
    logic [AW-1:0]    fail_addr;
    logic [AW:0]      load_cnt;
    logic [15:0]      result;

    bist_engine_if #(.STIM_W(STIM_W), .RESP_W(RESP_W)) ifc ();

    bist_engine #(
        .DEPTH(DEPTH), .STIM_W(STIM_W), .RESP_W(RESP_W), .LAT(LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tlr(tlr), .run(run), .bus(ifc),
        .busy(busy), .done(done), .fail(fail), .err_cnt(err_cnt),
        .fail_addr(fail_addr), .load_cnt(load_cnt), .result(result)
    );

    always #5 clk = ~clk;

    // Core model: one-cycle loopback of stimulus with a per-address corruption pattern.
    logic [3:0] corr [DEPTH];

    function automatic logic [3:0] corr_of(input logic [STIM_W-1:0] b);
        int a;
        a = int'(b) - 1;
        if (a < 0 || a >= DEPTH) return 4'h0;
        return corr[a];
    endfunction

    always @(posedge clk) ifc.bist_in <= ifc.bist_out[3:0] ^ corr_of(ifc.bist_out);

    typedef struct {
        int          n;
        int          stop_at;
        int          mask_addr;
        logic [3:0]  mask_val;
        logic [31:0] corr_nib;
        logic        exp_fail;
        int          exp_err;
        int          exp_addr;
        logic [15:0] exp_res;
        int          exp_busy;
        int          exp_drv;
    } vec_t;

    typedef struct {
        logic        f;
        int          e;
        int          a;
        logic [15:0] r;
        int          b;
        int          d;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[9];
    int checks = 0;
    int failures = 0;

    function automatic vec_t mk(int n, int stop_at, int mask_addr, logic [3:0] mask_val,
                                logic [31:0] corr_nib, logic f, int e, int a,
                                logic [15:0] r, int b, int d);
        vec_t v;
        v.n = n; v.stop_at = stop_at; v.mask_addr = mask_addr; v.mask_val = mask_val;
        v.corr_nib = corr_nib; v.exp_fail = f; v.exp_err = e; v.exp_addr = a;
        v.exp_res = r; v.exp_busy = b; v.exp_drv = d;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tlr_pulse();
        @(negedge clk); tlr = 1'b1;
        @(negedge clk); tlr = 1'b0;
    endtask

    task automatic load_table(input int n, input int stop_at, input int mask_addr,
                              input logic [3:0] mask_val);
        for (int a = 0; a < n; a++) begin
            @(negedge clk);
            ifc.load_en   = 1'b1;
            ifc.load_stim = STIM_W'(a + 1);
            ifc.load_exp  = RESP_W'(a + 1);
            ifc.load_mask = (a == mask_addr) ? mask_val : 4'hF;
            ifc.load_stop = (a == stop_at);
        end
        @(negedge clk);
        ifc.load_en = 1'b0;
    endtask

    task automatic run_and_wait(output int busy_c, output int drv_c, output logic ok);
        @(negedge clk); run = 1'b1;
        busy_c = 0; drv_c = 0; ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (busy) busy_c++;
            if (ifc.bist_out != '0) drv_c++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int   bc, dc;
        logic ok;
        exp_t e, got;

        ifc.load_en = 1'b0; ifc.load_stim = '0; ifc.load_exp = '0;
        ifc.load_mask = '0; ifc.load_stop = 1'b0;
        for (int a = 0; a < DEPTH; a++) corr[a] = 4'h0;

        //         n stop mA mV    corr          f e a  res      busy drv
        vecs[0] = mk(4, -1, -1, 4'h0, 32'h0000_0000, 0, 0, 0, 16'hFFFF, 5, 4);
        vecs[1] = mk(4, -1, -1, 4'h0, 32'h0000_0400, 1, 1, 2, 16'h0002, 5, 4);
        vecs[2] = mk(4, -1,  1, 4'h1, 32'h0000_0080, 0, 0, 0, 16'hFFFF, 5, 4);
        vecs[3] = mk(4, -1,  1, 4'h1, 32'h0000_0010, 1, 1, 1, 16'h0001, 5, 4);
        vecs[4] = mk(4,  1, -1, 4'h0, 32'h0000_0000, 0, 0, 0, 16'hFFFF, 3, 2);
        vecs[5] = mk(4, -1, -1, 4'h0, 32'h0000_102F, 1, 3, 0, 16'h0000, 5, 4);
        vecs[6] = mk(8, -1, -1, 4'h0, 32'h3333_3333, 1, 3, 0, 16'h0000, 9, 8);
        vecs[7] = mk(8,  5, -1, 4'h0, 32'h0F00_0000, 0, 0, 0, 16'hFFFF, 7, 6);
        vecs[8] = mk(4,  3, -1, 4'h0, 32'h0000_4000, 1, 1, 3, 16'h0003, 5, 4);

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_fail", 32'(fail), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        check("rst_fail_addr", 32'(fail_addr), 0);
        check("rst_load_cnt", 32'(load_cnt), 0);
        check("rst_result", 32'(result), 0);
        check("rst_bist_out", 32'(ifc.bist_out), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            tlr_pulse();
            load_table(vecs[i].n, vecs[i].stop_at, vecs[i].mask_addr, vecs[i].mask_val);
            for (int a = 0; a < DEPTH; a++) corr[a] = vecs[i].corr_nib[a*4 +: 4];
            check($sformatf("v%0d_load_cnt", i), 32'(load_cnt), 32'(vecs[i].n));
            e.f = vecs[i].exp_fail; e.e = vecs[i].exp_err; e.a = vecs[i].exp_addr;
            e.r = vecs[i].exp_res;  e.b = vecs[i].exp_busy; e.d = vecs[i].exp_drv;
            sbq.push_back(e);
            run_and_wait(bc, dc, ok);
            got = sbq.pop_front();
            check($sformatf("v%0d_done_seen", i), 32'(ok), 1);
            check($sformatf("v%0d_fail", i), 32'(fail), 32'(got.f));
            check($sformatf("v%0d_err_cnt", i), 32'(err_cnt), 32'(got.e));
            check($sformatf("v%0d_fail_addr", i), 32'(fail_addr), 32'(got.a));
            check($sformatf("v%0d_result", i), 32'(result), 32'(got.r));
            check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(got.b));
            check($sformatf("v%0d_drive_cycles", i), 32'(dc), 32'(got.d));
            run = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_done_clear", i), 32'(done), 0);
            check($sformatf("v%0d_result_held", i), 32'(result), 32'(got.r));
        end
        for (int a = 0; a < DEPTH; a++) corr[a] = 4'h0;

        tlr_pulse();
        check("tlr_clears_result", 32'(result), 0);
        load_table(DEPTH + 3, -1, -1, 4'h0);
        check("overload_load_cnt", 32'(load_cnt), 32'(DEPTH));

        tlr_pulse();
        @(negedge clk); run = 1'b1;
        @(negedge clk);
        check("empty_done", 32'(done), 1);
        check("empty_busy", 32'(busy), 0);
        check("empty_fail", 32'(fail), 0);
        check("empty_result", 32'(result), 32'h0000_FFFF);
        run = 1'b0;

        tlr_pulse();
        load_table(4, -1, -1, 4'h0);
        @(negedge clk); run = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_busy_mid", 32'(busy), 1);
        run = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_bist_out", 32'(ifc.bist_out), 0);

        tlr_pulse();
        load_table(4, -1, -1, 4'h0);
        @(negedge clk); run = 1'b1;
        repeat (2) @(negedge clk);
        check("arst_pre_bist_out", 32'(ifc.bist_out), 2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_bist_out", 32'(ifc.bist_out), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_load_cnt", 32'(load_cnt), 0);
        run = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); run = 1'b1;
        @(negedge clk);
        check("arst_rerun_done", 32'(done), 1);
        check("arst_rerun_fail", 32'(fail), 0);
        check("arst_rerun_result", 32'(result), 32'h0000_FFFF);
        run = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
